// File: rtl/bcd_serial_subtractor_if.sv
// Request/result bundle for the digit-serial BCD subtractor.
// The master side issues start with packed BCD operands; the slave side returns the result.
interface bcd_serial_subtractor_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   diff;
  logic                  neg;
  logic                  invalid;

  modport master (
    output start, a, b,
    input  busy, done, diff, neg, invalid
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, neg, invalid
  );
endinterface

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial BCD subtractor: A - B one digit per clock, LSD first. A negative ten's-complement
// result is turned into a magnitude by a second serial pass (0 - r).
module bcd_serial_subtractor #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  bcd_serial_subtractor_if.slave   bus
);

  localparam int unsigned W    = 4 * DIGITS;
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);

  typedef enum logic [1:0] {StIdle, StSub, StFix, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    r_q, r_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            borrow_q, borrow_d;
  logic [W-1:0]    diff_q, diff_d;
  logic            neg_q, neg_d;
  logic            invalid_q, invalid_d;

  logic [3:0]      step_x, step_y, step_digit;
  logic [4:0]      step_t;
  logic            step_bout;
  logic [W-1:0]    r_step;

  function automatic logic has_bad_nibble(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    r_d       = r_q;
    idx_d     = idx_q;
    borrow_d  = borrow_q;
    diff_d    = diff_q;
    neg_d     = neg_q;
    invalid_d = invalid_q;

    // SUB steps a - b; FIX steps 0 - r to undo the ten's complement.
    step_x = 4'd0;
    step_y = 4'd0;
    if (state_q == StSub) begin
      step_x = a_q[int'(idx_q)*4 +: 4];
      step_y = b_q[int'(idx_q)*4 +: 4];
    end else if (state_q == StFix) begin
      step_y = r_q[int'(idx_q)*4 +: 4];
    end

    step_t = {1'b0, step_x} - {1'b0, step_y} - {4'd0, borrow_q};
    if (step_t[4]) begin
      step_digit = step_t[3:0] + 4'd10;
      step_bout  = 1'b1;
    end else begin
      step_digit = step_t[3:0];
      step_bout  = 1'b0;
    end

    r_step = r_q;
    r_step[int'(idx_q)*4 +: 4] = step_digit;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d      = bus.a;
          b_d      = bus.b;
          idx_d    = '0;
          borrow_d = 1'b0;
          if (has_bad_nibble(bus.a) || has_bad_nibble(bus.b)) begin
            state_d   = StDone;
            diff_d    = '0;
            neg_d     = 1'b0;
            invalid_d = 1'b1;
          end else begin
            state_d = StSub;
          end
        end
      end
      StSub: begin
        r_d = r_step;
        if (idx_q == LastIdx) begin
          idx_d    = '0;
          borrow_d = 1'b0;
          if (step_bout) begin
            state_d = StFix;
          end else begin
            state_d   = StDone;
            diff_d    = r_step;
            neg_d     = 1'b0;
            invalid_d = 1'b0;
          end
        end else begin
          idx_d    = idx_q + 1'b1;
          borrow_d = step_bout;
        end
      end
      StFix: begin
        r_d = r_step;
        if (idx_q == LastIdx) begin
          idx_d     = '0;
          borrow_d  = 1'b0;
          state_d   = StDone;
          diff_d    = r_step;
          neg_d     = 1'b1;
          invalid_d = 1'b0;
        end else begin
          idx_d    = idx_q + 1'b1;
          borrow_d = step_bout;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      r_q       <= '0;
      idx_q     <= '0;
      borrow_q  <= 1'b0;
      diff_q    <= '0;
      neg_q     <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      r_q       <= r_d;
      idx_q     <= idx_d;
      borrow_q  <= borrow_d;
      diff_q    <= diff_d;
      neg_q     <= neg_d;
      invalid_q <= invalid_d;
    end
  end

  assign bus.busy    = (state_q != StIdle);
  assign bus.done    = (state_q == StDone);
  assign bus.diff    = diff_q;
  assign bus.neg     = neg_q;
  assign bus.invalid = invalid_q;

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Self-checking bench: directed cases plus random operands against an integer reference model.
module tb_bcd_serial_subtractor;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned W      = 4 * DIGITS;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   done_cnt;

  bcd_serial_subtractor_if #(.DIGITS(DIGITS)) bus ();

  bcd_serial_subtractor #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_bad(input logic [W-1:0] v);
    bit bad;
    bad = 0;
    for (int i = 0; i < int'(DIGITS); i++) if (v[4*i +: 4] > 4'd9) bad = 1;
    return bad;
  endfunction

  function automatic int to_int(input logic [W-1:0] v);
    int r;
    r = 0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < int'(DIGITS); i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Call #1 after a rising edge; returns #1 after the edge that ends the DONE cycle.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv);
    int ea, eb, lat, k;
    bit inv, seen;
    logic [W-1:0] ediff;
    logic eneg;
    inv = is_bad(av) || is_bad(bv);
    ea  = to_int(av);
    eb  = to_int(bv);
    if (inv) begin
      ediff = '0; eneg = 1'b0; lat = 1;
    end else if (ea >= eb) begin
      ediff = to_bcd(ea - eb); eneg = 1'b0; lat = int'(DIGITS) + 1;
    end else begin
      ediff = to_bcd(eb - ea); eneg = 1'b1; lat = 2 * int'(DIGITS) + 1;
    end
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    k    = 0;
    seen = 0;
    while (!seen && k < 50) begin
      @(negedge clk);
      k++;
      if (bus.done === 1'b1) seen = 1;
      else check("busy_during_op", 32'(bus.busy), 32'd1);
    end
    check("latency", k, lat);
    check("diff", 32'(bus.diff), 32'(ediff));
    check("neg", 32'(bus.neg), 32'(eneg));
    check("invalid", 32'(bus.invalid), 32'(inv));
    check("busy_in_done", 32'(bus.busy), 32'd1);
    @(posedge clk);
    #1;
    check("busy_after", 32'(bus.busy), 32'd0);
    check("done_after", 32'(bus.done), 32'd0);
    check("diff_hold", 32'(bus.diff), 32'(ediff));
  endtask

  initial begin
    int base;
    logic [W-1:0] ra, rb;
    errors    = 0;
    checks    = 0;
    done_cnt  = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    #12;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_diff", 32'(bus.diff), 32'd0);
    check("rst_neg", 32'(bus.neg), 32'd0);
    check("rst_invalid", 32'(bus.invalid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op(16'h5432, 16'h1234);
    run_op(16'h1234, 16'h5432);
    run_op(16'h0000, 16'h0001);
    run_op(16'h9999, 16'h9999);
    run_op(16'h1000, 16'h0001);
    run_op(16'h12A4, 16'h0001);
    run_op(16'h0009, 16'h0003);

    // Starts at edges 2 and 5 of a busy operation must be ignored.
    base      = done_cnt;
    bus.start = 1'b1; bus.a = 16'h5432; bus.b = 16'h1234;
    @(posedge clk); #1;                 // edge 0
    bus.start = 1'b0;
    @(posedge clk); #1;                 // edge 1
    bus.start = 1'b1; bus.a = 16'h0000; bus.b = 16'h9999;
    @(posedge clk); #1;                 // edge 2
    bus.start = 1'b0;
    @(posedge clk); #1;                 // edge 3
    @(posedge clk); #1;                 // edge 4
    bus.start = 1'b1;
    @(posedge clk); #1;                 // edge 5
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("ignored_start_done_count", 32'(done_cnt - base), 32'd1);
    check("ignored_start_diff", 32'(bus.diff), 32'h4198);
    check("ignored_start_neg", 32'(bus.neg), 32'd0);
    check("ignored_start_busy", 32'(bus.busy), 32'd0);

    // Reset mid-operation, with a nonzero previous result on the outputs.
    run_op(16'h1234, 16'h5432);
    base      = done_cnt;
    bus.start = 1'b1; bus.a = 16'h0000; bus.b = 16'h0001;
    @(posedge clk); #1;                 // edge 0
    bus.start = 1'b0;
    repeat (3) @(posedge clk);          // edge 3
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_diff", 32'(bus.diff), 32'd0);
    check("midrst_neg", 32'(bus.neg), 32'd0);
    check("midrst_invalid", 32'(bus.invalid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("midrst_no_done", 32'(done_cnt - base), 32'd0);
    run_op(16'h0000, 16'h0001);

    // Random operands, some with an out-of-range nibble.
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        ra[4*i +: 4] = 4'($urandom_range(0, 9));
        rb[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 7) == 0) ra[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
      if ($urandom_range(0, 7) == 0) rb[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
      run_op(ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_serial_subtractor.md
# bcd_serial_subtractor

Digit-serial BCD subtractor for the BCD arithmetic datapath, the inverse-direction companion to the existing ripple BCD adder. It accepts two packed unsigned BCD operands, computes A − B one decimal digit per clock from the least-significant digit upward, and returns the magnitude in BCD with a separate sign flag. Negative results are converted from ten's complement to magnitude by a second serial pass. Requests and results use a start/done handshake.

## Interface
- DIGITS, 4, number of BCD digits per operand (≥1)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  4*DIGITS  minuend, packed BCD, digit 0 in [3:0]
- b  input  4*DIGITS  subtrahend, packed BCD, same packing
- busy  output  1  high whenever state ≠ IDLE
- done  output  1  one-cycle pulse; result outputs valid from this cycle
- diff  output  4*DIGITS  |A − B| in packed BCD
- neg  output  1  1 when A < B
- invalid  output  1  1 when any nibble of a or b exceeds 9

## Operation
- States: IDLE, SUB, FIX, DONE.
- IDLE with start=1: latch a and b into internal registers, clear digit index and borrow.
  - If any latched nibble > 9: next state DONE; diff=0, neg=0, invalid=1.
  - Otherwise: next state SUB; invalid=0.
- Digit step, used by SUB and FIX, one per clock: t = x − y − bin as a 5-bit two's-complement value.
  - If t < 0: digit = (t + 10)[3:0], bout = 1.
  - Else: digit = t[3:0], bout = 0.
- SUB: x = a digit[idx], y = b digit[idx]. Write the result into working register r digit[idx]. Register borrow, then idx += 1.
  - After digit DIGITS−1, if final bout = 1: go to FIX with idx = 0, borrow = 0, neg = 1.
  - Otherwise: go to DONE with neg = 0.
- FIX: x = 0, y = r digit[idx], same step, result written back to r digit[idx]. This converts the ten's complement to magnitude. After digit DIGITS−1, go to DONE; the final borrow is discarded.
- DONE: done = 1 for exactly one cycle. Copy r to diff, or 0 if invalid. Return to IDLE.
- diff, neg and invalid hold their values until the next accepted start. They are updated only on entry to DONE.
- start is ignored while busy = 1, including on the DONE cycle. Operand changes while busy have no effect.
- A result of zero always gives neg = 0.

## Timing
- Reset (rst_n low, asynchronous): state = IDLE, idx = 0, borrow = 0, r = 0. Outputs: busy = 0, done = 0, diff = 0, neg = 0, invalid = 0. Applies immediately, including mid-operation. The in-flight operation is discarded and no done is produced.
- Edge numbering: start is sampled high at edge 0.
- Latency from edge 0 to the edge that asserts done:
  - A ≥ B: DIGITS + 1 edges.
  - A < B: 2·DIGITS + 1 edges.
  - Invalid operand: 1 edge.
- busy rises at edge 0 and falls at the edge that ends the DONE cycle.
- Earliest next accepted start: the cycle after done, when the FSM is in IDLE.
- Back-to-back throughput for A ≥ B: one result per DIGITS + 2 cycles.

## Test plan
- DIGITS=4, a=16'h5432, b=16'h1234, one-cycle start → done at edge 5, diff=16'h4198, neg=0, invalid=0; busy high for edges 0–5.
- a=16'h1234, b=16'h5432 → done at edge 9, diff=16'h4198, neg=1.
- Boundaries:
  - a=16'h0000, b=16'h0001 → diff=16'h0001, neg=1, done at edge 9.
  - a=16'h9999, b=16'h9999 → diff=16'h0000, neg=0, done at edge 5.
  - a=16'h1000, b=16'h0001 → diff=16'h0999, neg=0. Exercises the borrow ripple through three digits.
- a=16'h12A4, b=16'h0001 → done at edge 1, invalid=1, diff=0, neg=0. A following valid request (a=16'h0009, b=16'h0003) clears invalid and gives diff=16'h0006.
- Start pulsed again at edges 2 and 5 during a busy operation → ignored; the first result is unchanged and exactly one done pulse occurs.
- rst_n pulsed low at edge 3 of an operation → all outputs 0 immediately and no done pulse. A new start after release completes normally.
